// File: rtl/common_pkg.sv
// Types shared across the core's sequencing and decode logic.
package common_pkg;

   typedef enum logic [2:0] {
      WARP_IDLE,
      WARP_FETCH,
      WARP_DECODE,
      WARP_EXECUTE,
      WARP_MEM,
      WARP_WRITEBACK,
      WARP_DONE
   } warp_state_t;

endpackage

// File: rtl/warp_scheduler.sv
// Round-robin warp sequencer that time-multiplexes the shared fetch/decode/execute
// datapath, one instruction per turn, and reports when every launched warp has halted.
module warp_scheduler
   import common_pkg::*;
#(
   parameter int NUM_WARPS = 4,
   localparam int WID_W = $clog2(NUM_WARPS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NUM_WARPS-1:0] warp_mask,
   output logic                 fetch_req,
   input  logic                 fetch_valid,
   input  logic                 Finish,
   input  logic                 DMemEN,
   output logic                 mem_req,
   input  logic                 mem_done,
   output warp_state_t          warp_state,
   output logic [WID_W-1:0]     cur_warp,
   output logic [NUM_WARPS-1:0] warp_done,
   output logic                 done
);

   warp_state_t          next_state;
   logic [WID_W-1:0]     next_warp;
   logic [NUM_WARPS-1:0] next_done;
   logic [NUM_WARPS-1:0] retired;
   logic [WID_W-1:0]     probe;
   logic [WID_W-1:0]     pick_idx;
   logic                 pick_found;
   logic [WID_W-1:0]     first_idx;
   warp_state_t          sel_state;
   logic [WID_W-1:0]     sel_warp;

   assign fetch_req = (warp_state == WARP_FETCH);
   assign mem_req   = (warp_state == WARP_MEM);
   assign done      = (warp_state == WARP_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         warp_state <= WARP_IDLE;
         cur_warp   <= '0;
         warp_done  <= '0;
      end else begin
         warp_state <= next_state;
         cur_warp   <= next_warp;
         warp_done  <= next_done;
      end
   end

   always_comb begin
      next_state = warp_state;
      next_warp  = cur_warp;
      next_done  = warp_done;
      probe      = cur_warp;
      pick_idx   = cur_warp;
      pick_found = 1'b0;
      first_idx  = '0;

      // A Finish retiring the current warp must already be visible to the rotation scan.
      retired = warp_done;
      if (warp_state == WARP_EXECUTE && Finish)
         retired[cur_warp] = 1'b1;

      // Offsets wrap modulo NUM_WARPS, so the final probe lands on cur_warp itself.
      for (int i = 1; i <= NUM_WARPS; i++) begin
         probe = cur_warp + WID_W'(i);
         if (!pick_found && !retired[probe]) begin
            pick_found = 1'b1;
            pick_idx   = probe;
         end
      end

      for (int i = NUM_WARPS - 1; i >= 0; i--) begin
         if (warp_mask[i])
            first_idx = WID_W'(i);
      end

      sel_state = pick_found ? WARP_FETCH : WARP_DONE;
      sel_warp  = pick_found ? pick_idx : cur_warp;

      case (warp_state)
         WARP_IDLE: begin
            if (start) begin
               next_done = ~warp_mask;
               if (warp_mask == '0) begin
                  next_state = WARP_DONE;
               end else begin
                  next_warp  = first_idx;
                  next_state = WARP_FETCH;
               end
            end
         end
         WARP_FETCH: begin
            if (fetch_valid)
               next_state = WARP_DECODE;
         end
         WARP_DECODE: next_state = WARP_EXECUTE;
         WARP_EXECUTE: begin
            if (Finish) begin
               next_done  = retired;
               next_state = sel_state;
               next_warp  = sel_warp;
            end else if (DMemEN) begin
               next_state = WARP_MEM;
            end else begin
               next_state = WARP_WRITEBACK;
            end
         end
         WARP_MEM: begin
            if (mem_done)
               next_state = WARP_WRITEBACK;
         end
         WARP_WRITEBACK: begin
            next_state = sel_state;
            next_warp  = sel_warp;
         end
         WARP_DONE: begin
            if (!start)
               next_state = WARP_IDLE;
         end
         default: next_state = WARP_IDLE;
      endcase
   end

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a behavioural round-robin model.
module tb_warp_scheduler;
   import common_pkg::*;

   localparam int NUM_WARPS = 4;
   localparam int WID_W = 2;

   logic                 clk;
   logic                 reset;
   logic                 start;
   logic [NUM_WARPS-1:0] warp_mask;
   logic                 fetch_req;
   logic                 fetch_valid;
   logic                 Finish;
   logic                 DMemEN;
   logic                 mem_req;
   logic                 mem_done;
   warp_state_t          warp_state;
   logic [WID_W-1:0]     cur_warp;
   logic [NUM_WARPS-1:0] warp_done;
   logic                 done;

   int testsRun = 0;
   int testsFailed = 0;
   bit checkEn = 0;

   warp_state_t mPhase;
   int          mCur;
   bit          mDone[NUM_WARPS];

   warp_scheduler #(.NUM_WARPS(NUM_WARPS)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .warp_mask(warp_mask),
      .fetch_req(fetch_req),
      .fetch_valid(fetch_valid),
      .Finish(Finish),
      .DMemEN(DMemEN),
      .mem_req(mem_req),
      .mem_done(mem_done),
      .warp_state(warp_state),
      .cur_warp(cur_warp),
      .warp_done(warp_done),
      .done(done)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [NUM_WARPS-1:0] msk, input logic fv,
                                input logic fin, input logic dm, input logic md);
      start       = st;
      warp_mask   = msk;
      fetch_valid = fv;
      Finish      = fin;
      DMemEN      = dm;
      mem_done    = md;
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [NUM_WARPS-1:0] modelDoneVec();
      logic [NUM_WARPS-1:0] v = '0;
      for (int i = 0; i < NUM_WARPS; i++) v[i] = mDone[i];
      return v;
   endfunction

   // Give the datapath to the next unfinished warp after mCur, wrapping round to mCur last.
   task automatic modelPickNext();
      for (int k = 1; k <= NUM_WARPS; k++) begin
         int w = (mCur + k) % NUM_WARPS;
         if (!mDone[w]) begin
            mCur   = w;
            mPhase = WARP_FETCH;
            return;
         end
      end
      mPhase = WARP_DONE;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mPhase = WARP_IDLE;
         mCur   = 0;
         for (int i = 0; i < NUM_WARPS; i++) mDone[i] = 0;
      end else begin
         case (mPhase)
            WARP_IDLE: if (start) begin
               for (int i = 0; i < NUM_WARPS; i++) mDone[i] = !warp_mask[i];
               if (warp_mask == 0) mPhase = WARP_DONE;
               else begin
                  mCur = NUM_WARPS;
                  for (int i = 0; i < NUM_WARPS; i++) if (warp_mask[i] && mCur == NUM_WARPS) mCur = i;
                  mPhase = WARP_FETCH;
               end
            end
            WARP_FETCH:   if (fetch_valid) mPhase = WARP_DECODE;
            WARP_DECODE:  mPhase = WARP_EXECUTE;
            WARP_EXECUTE: begin
               if (Finish) begin
                  mDone[mCur] = 1;
                  modelPickNext();
               end else if (DMemEN) mPhase = WARP_MEM;
               else mPhase = WARP_WRITEBACK;
            end
            WARP_MEM:       if (mem_done) mPhase = WARP_WRITEBACK;
            WARP_WRITEBACK: modelPickNext();
            WARP_DONE:      if (!start) mPhase = WARP_IDLE;
            default:        mPhase = WARP_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("model state", 32'(warp_state), 32'(mPhase));
         checkOutput("model cur_warp", 32'(cur_warp), 32'(mCur));
         checkOutput("model warp_done", 32'(warp_done), 32'(modelDoneVec()));
         checkOutput("model fetch_req", 32'(fetch_req), 32'(mPhase == WARP_FETCH));
         checkOutput("model mem_req", 32'(mem_req), 32'(mPhase == WARP_MEM));
         checkOutput("model done", 32'(done), 32'(mPhase == WARP_DONE));
      end
   end

   initial begin
      int memCycles;
      bit stayedDone;
      reset = 0;
      applyStimulus(0, 4'b0000, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset state", 32'(warp_state), 32'(WARP_IDLE));
      checkOutput("reset cur_warp", 32'(cur_warp), 0);
      checkOutput("reset warp_done", 32'(warp_done), 0);
      checkOutput("reset done/reqs", {29'b0, done, fetch_req, mem_req}, 0);
      reset = 1;
      checkEn = 1;

      // Two active warps alternate, 4 cycles per turn.
      applyStimulus(1, 4'b0101, 1, 0, 0, 0);
      waitCycle();
      applyStimulus(0, 4'b0101, 1, 0, 0, 0);
      for (int t = 0; t < 4; t++) begin
         checkOutput($sformatf("rr turn %0d state", t), 32'(warp_state), 32'(WARP_FETCH));
         checkOutput($sformatf("rr turn %0d warp", t), 32'(cur_warp), (t % 2 == 0) ? 0 : 2);
         repeat (4) waitCycle();
      end
      checkOutput("rr warp_done", 32'(warp_done), 32'b1010);

      repeat (4) waitCycle();
      checkOutput("pre-finish warp", 32'(cur_warp), 2);
      repeat (2) waitCycle();
      checkOutput("warp2 execute", 32'(warp_state), 32'(WARP_EXECUTE));
      Finish = 1;
      waitCycle();
      Finish = 0;
      checkOutput("retire2 warp_done", 32'(warp_done), 32'b1110);
      checkOutput("retire2 next warp", 32'(cur_warp), 0);
      repeat (2) waitCycle();
      Finish = 1;
      waitCycle();
      Finish = 0;
      checkOutput("all retired state", 32'(warp_state), 32'(WARP_DONE));
      checkOutput("all retired done", 32'(done), 1);
      checkOutput("all retired warp_done", 32'(warp_done), 32'b1111);
      waitCycle();
      checkOutput("back to idle", 32'(warp_state), 32'(WARP_IDLE));

      // Single warp with a three-cycle memory access.
      applyStimulus(1, 4'b0010, 1, 0, 0, 0);
      waitCycle();
      start = 0;
      checkOutput("single warp", 32'(cur_warp), 1);
      repeat (2) waitCycle();
      DMemEN = 1;
      waitCycle();
      DMemEN = 0;
      memCycles = 0;
      for (int c = 0; c < 3; c++) begin
         if (mem_req) memCycles++;
         if (c == 2) mem_done = 1;
         waitCycle();
      end
      mem_done = 0;
      checkOutput("mem_req cycles", memCycles, 3);
      checkOutput("post-mem state", 32'(warp_state), 32'(WARP_WRITEBACK));
      waitCycle();
      checkOutput("refetch state", 32'(warp_state), 32'(WARP_FETCH));
      checkOutput("refetch warp", 32'(cur_warp), 1);
      repeat (2) waitCycle();
      Finish = 1;
      waitCycle();
      Finish = 0;
      waitCycle();

      // Empty launch and held start.
      applyStimulus(1, 4'b0000, 0, 0, 0, 0);
      waitCycle();
      checkOutput("empty launch state", 32'(warp_state), 32'(WARP_DONE));
      checkOutput("empty launch warp_done", 32'(warp_done), 32'b1111);
      stayedDone = 1;
      for (int c = 0; c < 5; c++) begin
         waitCycle();
         if (warp_state != WARP_DONE || !done) stayedDone = 0;
      end
      checkOutput("held start stays done", stayedDone, 1);
      start = 0;
      waitCycle();
      checkOutput("drop start idle", 32'(warp_state), 32'(WARP_IDLE));
      checkOutput("drop start done", 32'(done), 0);

      // Asynchronous reset in the middle of a memory access.
      applyStimulus(1, 4'b1111, 1, 0, 0, 0);
      waitCycle();
      start = 0;
      repeat (2) waitCycle();
      DMemEN = 1;
      waitCycle();
      DMemEN = 0;
      checkOutput("mem before reset", 32'(mem_req), 1);
      #1 reset = 0;
      #1;
      checkOutput("async reset mem_req", 32'(mem_req), 0);
      checkOutput("async reset state", 32'(warp_state), 32'(WARP_IDLE));
      #4 reset = 1;
      waitCycle();
      applyStimulus(1, 4'b1111, 1, 0, 0, 0);
      waitCycle();
      start = 0;
      checkOutput("relaunch warp", 32'(cur_warp), 0);

      // Finish outranks DMemEN.
      repeat (2) waitCycle();
      Finish = 1;
      DMemEN = 1;
      waitCycle();
      Finish = 0;
      DMemEN = 0;
      checkOutput("finish+mem state", 32'(warp_state), 32'(WARP_FETCH));
      checkOutput("finish+mem mem_req", 32'(mem_req), 0);
      checkOutput("finish+mem warp", 32'(cur_warp), 1);
      checkOutput("finish+mem warp_done", 32'(warp_done), 32'b0001);

      // Randomized traffic; the compare process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         waitCycle();
         if ($urandom_range(0, 199) == 0) begin
            #1 reset = 0;
            #5 reset = 1;
         end else begin
            applyStimulus($urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                          $urandom_range(0, 2) == 0);
         end
      end

      waitCycle();
      checkEn = 0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Per-core sequencer for the shared fetch/decode/execute datapath.
- Time-multiplexes the datapath among NUM_WARPS warps, one instruction per turn, in round-robin order.
- Drives warp_state, which the decoder uses to latch its outputs in WARP_DECODE.
- Tracks per-warp completion from decoder Finish and raises done when every active warp has halted.

Parameters:
- NUM_WARPS, 4, number of warps in the core; must be ≥2 and a power of 2.
- WID_W, $clog2(NUM_WARPS), warp index width; derived, not overridden.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  kernel launch request; sampled only in WARP_IDLE and WARP_DONE.
- warp_mask  input  NUM_WARPS  active warps for this launch; sampled when start is accepted.
- fetch_req  output  1  instruction fetch request for cur_warp.
- fetch_valid  input  1  instruction word available at decoder input.
- Finish  input  1  registered decoder HALT flag; valid in WARP_EXECUTE.
- DMemEN  input  1  registered decoder load/store flag; valid in WARP_EXECUTE.
- mem_req  output  1  data memory access request.
- mem_done  input  1  data memory access complete.
- warp_state  output  warp_state_t  current sequencer state (common_pkg enum).
- cur_warp  output  WID_W  warp currently owning the datapath.
- warp_done  output  NUM_WARPS  per-warp halted or inactive flags.
- done  output  1  all warps complete.

Behaviour:
- States (warp_state_t): WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_EXECUTE, WARP_MEM, WARP_WRITEBACK, WARP_DONE.
- Reset (async, reset==0): warp_state=WARP_IDLE, cur_warp=0, warp_done=0, done=0, fetch_req=0, mem_req=0.
  - Applies immediately, including mid-FETCH or mid-MEM; any in-flight request is abandoned.
- fetch_req is 1 exactly when warp_state==WARP_FETCH. mem_req is 1 exactly when warp_state==WARP_MEM. Both are pure decodes of the state register; they carry no extra latency.
- WARP_IDLE, start=1:
  - warp_done <= ~warp_mask.
  - If warp_mask==0 → WARP_DONE.
  - Otherwise cur_warp <= lowest set bit of warp_mask, → WARP_FETCH.
- WARP_FETCH: hold until fetch_valid=1, then → WARP_DECODE. A fetch_valid in cycle k gives WARP_DECODE in cycle k+1.
- WARP_DECODE: exactly one cycle, → WARP_EXECUTE.
- WARP_EXECUTE: exactly one cycle. Priority order:
  - Finish=1: warp_done[cur_warp] <= 1, then select-next. DMemEN is ignored.
  - Else DMemEN=1: → WARP_MEM.
  - Else: → WARP_WRITEBACK.
- WARP_MEM: hold until mem_done=1, then → WARP_WRITEBACK.
- WARP_WRITEBACK: exactly one cycle, then select-next.
- Select-next (rotating priority):
  - Scan cur_warp+1, cur_warp+2, … mod NUM_WARPS, ending with cur_warp itself.
  - The first index with warp_done==0, using the updated warp_done that includes a Finish in the same cycle, becomes cur_warp → WARP_FETCH.
  - If no such index exists → WARP_DONE; cur_warp is held.
- WARP_DONE: done=1, all warp_done bits are 1, and outputs are stable. When start==0 → WARP_IDLE, done <= 0. While start stays 1, the block remains in WARP_DONE, so a held start cannot relaunch.
- Ignored inputs:
  - start outside WARP_IDLE and WARP_DONE.
  - fetch_valid outside WARP_FETCH.
  - mem_done outside WARP_MEM.
  - Finish and DMemEN outside WARP_EXECUTE.
- Latency for one instruction with no memory access and fetch_valid in the first FETCH cycle: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK). A Finish instruction takes 3 cycles.

Test Plan:
1. Reset, then start with warp_mask=4'b0101, fetch_valid tied 1, Finish=0, DMemEN=0 → cur_warp sequence 0,2,0,2; each turn is 4 cycles FETCH→DECODE→EXECUTE→WRITEBACK; warp_done=4'b1010.
2. Continue test 1; assert Finish=1 in warp 2 EXECUTE → warp_done=4'b1110, next turns warp 0 only. Then Finish=1 on warp 0 → warp_done=4'b1111, WARP_DONE next cycle, done=1.
3. Single warp, DMemEN=1 in EXECUTE, mem_done delayed 3 cycles → mem_req high for exactly 3 cycles (mem_done arrives in the third), then WRITEBACK 1 cycle, then FETCH of the same warp.
4. start with warp_mask=0 → WARP_DONE next cycle, done=1, warp_done=4'b1111. Hold start=1 for 5 cycles → remains in WARP_DONE. Drop start → WARP_IDLE, done=0.
5. Drive reset low asynchronously mid-WARP_MEM, between clock edges → mem_req=0 and warp_state=WARP_IDLE immediately; after release, start relaunches from warp 0.
6. In EXECUTE with Finish=1 and DMemEN=1 together → no WARP_MEM entry, mem_req stays 0, warp retired.
